// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit storage/shift register with single-cycle operations and a
// counted burst-shift engine reporting busy/done.
module shift_reg_univ #(
  parameter int                 WIDTH     = 8,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0,
  localparam int                AW        = $clog2(WIDTH) + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             done_q, done_d;

  logic [2:0]       sh_sel;
  logic [WIDTH-1:0] sh_val;
  logic             sh_out;
  logic             mode_is_shift;

  assign mode_is_shift = (mode >= 3'd2) && (mode <= 3'd5);

  // One shifter serves both single ops (live mode) and bursts (latched op).
  assign sh_sel = (state_q == RUN) ? op_q : mode;

  always_comb begin
    sh_val = q_q;
    sh_out = sout_q;
    case (sh_sel)
      3'd2: begin sh_val = {q_q[WIDTH-2:0], sin};         sh_out = q_q[WIDTH-1]; end
      3'd3: begin sh_val = {sin, q_q[WIDTH-1:1]};         sh_out = q_q[0];       end
      3'd4: begin sh_val = {q_q[WIDTH-2:0], q_q[WIDTH-1]}; sh_out = q_q[WIDTH-1]; end
      3'd5: begin sh_val = {q_q[0], q_q[WIDTH-1:1]};      sh_out = q_q[0];       end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      q_q     <= RESET_VAL;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    q_d     = q_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && mode_is_shift) begin
          state_d = RUN;
          cnt_d   = amt;
          op_d    = mode;
        end else if (en) begin
          case (mode)
            3'd1:                     q_d = d;
            3'd2, 3'd3, 3'd4, 3'd5: begin
              q_d    = sh_val;
              sout_d = sh_out;
            end
            3'd6:                     q_d = '0;
            3'd7:                     q_d = RESET_VAL;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q != '0) begin
          q_d    = sh_val;
          sout_d = sh_out;
          cnt_d  = cnt_q - AW'(1);
        end else begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    q    = q_q;
    sout = sout_q;
    busy = (state_q == RUN);
    done = done_q;
  end

endmodule

// File: tb/tb_shift_reg_univ.sv
// Randomized bench for shift_reg_univ against a transaction-level arithmetic model.
module tb_shift_reg_univ;

  localparam int W = 8;
  localparam logic [7:0] RV = 8'hA5;

  logic       clk, rst_n, en, sin, start;
  logic [2:0] mode;
  logic [7:0] d;
  logic [4:0] amt;
  logic [7:0] q;
  logic       sout, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mq;
  logic       ms;

  shift_reg_univ #(.WIDTH(W), .RESET_VAL(RV)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .d(d), .sin(sin),
    .start(start), .amt(amt), .q(q), .sout(sout), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Apply one operation to the model using plain integer arithmetic.
  task automatic model_op(input int m, input int dv, input int s);
    int qi;
    qi = int'(mq);
    case (m)
      1: mq = dv[7:0];
      2: begin ms = qi[7]; qi = ((qi * 2) + s) % 256;            mq = qi[7:0]; end
      3: begin ms = qi[0]; qi = (qi / 2) + s * 128;              mq = qi[7:0]; end
      4: begin ms = qi[7]; qi = ((qi * 2) % 256) + (qi / 128);   mq = qi[7:0]; end
      5: begin ms = qi[0]; qi = (qi / 2) + (qi % 2) * 128;       mq = qi[7:0]; end
      6: mq = 8'h00;
      7: mq = RV;
      default: ;
    endcase
  endtask

  task automatic single(input int e, input int m, input int dv, input int s, input int st);
    en = e[0]; mode = m[2:0]; d = dv[7:0]; sin = s[0]; start = st[0];
    amt = 5'($urandom);
    tick;
    if (e != 0) model_op(m, dv, s);
    en = 1'b0; start = 1'b0;
    chk("op_q", q, mq);
    chk("op_sout", sout, ms);
    chk("op_busy", busy, 0);
    chk("op_done", done, 0);
  endtask

  task automatic burst(input int op, input int n, input int sinv);
    int s;
    start = 1'b1; mode = op[2:0]; amt = n[4:0];
    en = 1'($urandom); d = 8'($urandom); sin = 1'($urandom);
    tick;
    start = 1'b0;
    chk("brst_busy_start", busy, 1);
    chk("brst_q_start", q, mq);
    for (int i = 0; i < n; i++) begin
      s = (sinv < 0) ? int'($urandom_range(0, 1)) : sinv;
      sin = s[0];
      start = 1'($urandom); en = 1'b1; mode = 3'($urandom);
      d = 8'($urandom); amt = 5'($urandom);
      tick;
      model_op(op, 0, s);
      chk("brst_q", q, mq);
      chk("brst_sout", sout, ms);
      chk("brst_busy", busy, 1);
      chk("brst_done_early", done, 0);
    end
    tick;
    chk("brst_busy_end", busy, 0);
    chk("brst_done", done, 1);
    chk("brst_q_end", q, mq);
    start = 1'b0; en = 1'b0;
    tick;
    chk("brst_done_fall", done, 0);
    chk("brst_idle_q", q, mq);
  endtask

  task automatic async_reset;
    #2 rst_n = 1'b0;
    #1;
    mq = RV; ms = 1'b0;
    chk("rst_q", q, RV);
    chk("rst_sout", sout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1; en = 1'b0; start = 1'b0; mode = 3'd0; d = 8'h00; sin = 1'b0; amt = 5'd0;
    mq = RV; ms = 1'b0;
    tick;
    async_reset;

    single(1, 1, 8'h3C, 0, 0);
    chk("load_3c", q, 8'h3C);

    single(1, 1, 8'h81, 0, 0);
    single(1, 2, 0, 0, 0);
    chk("shl_const", q, 8'h02);
    single(1, 5, 0, 0, 0);
    chk("ror_const", q, 8'h01);
    single(1, 3, 0, 1, 0);
    chk("shr_const", q, 8'h80);

    single(1, 1, 8'h96, 0, 0);
    burst(4, 3, -1);
    chk("rol_burst_b4", q, 8'hB4);

    burst(2, 0, -1);

    single(1, 1, 8'hFF, 0, 0);
    burst(2, 9, 0);
    chk("shl9_zero", q, 8'h00);

    single(1, 1, 8'h77, 0, 1);
    chk("inv_start_load", q, 8'h77);

    // Reset in the middle of a burst: two shifts then abort.
    start = 1'b1; mode = 3'd3; amt = 5'd6; sin = 1'b1;
    tick;
    start = 1'b0;
    tick; tick;
    async_reset;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
      chk("post_rst_q", q, RV);
    end
    burst(3, 4, -1);

    for (int it = 0; it < 60; it++) begin
      int m;
      if ($urandom_range(0, 2) == 0) begin
        m = int'($urandom_range(2, 5));
        burst(m, ($urandom_range(0, 7) == 0) ? 31 : int'($urandom_range(0, 12)), -1);
      end else begin
        m = int'($urandom_range(0, 7));
        single(int'($urandom_range(0, 3) != 0), m, int'($urandom_range(0, 255)),
               int'($urandom_range(0, 1)),
               ((m >= 2) && (m <= 5)) ? 0 : int'($urandom_range(0, 1)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
